// File: rtl/fpu_seq_ctrl.sv
// fpu_seq_ctrl: sequencer between decode, the FPU datapath and writeback.
//
// The controller accepts one floating-point operation at a time. It issues a
// start pulse to the FPU, waits a class-dependent fixed latency (or, for
// FDIV, for in_fpu_done), and then presents the result to writeback.
//
// Parameters
//   LAT_ADD    : WAIT cycles for add/sub (000) and convert (100), 1-8
//   LAT_MUL    : WAIT cycles for multiply (001), 1-8
//   LAT_SIMPLE : WAIT cycles for classes 011, 101, 110, 111, 1-8
//   TIMEOUT    : maximum FDIV WAIT cycles when the timeout is enabled, 2-127
//
// Ports
//   in_clk, in_rst_n  : clock and asynchronous active-low reset
//   in_valid, in_fp_op: operation request from decode and its op class
//   in_flush          : pipeline flush, discards the in-flight operation
//   in_fpu_done       : FDIV completion from the FPU
//   in_wb_ready       : writeback accepts the result
//   out_fpu_start     : one-cycle start pulse (high in ISSUE)
//   out_fpu_op        : latched op class
//   out_fpu_kill      : one-cycle abort pulse (flush, or FDIV timeout)
//   out_stall         : front-end stall
//   out_wb_valid      : result available for writeback
//   out_wb_op         : op class of the result being written back
//   out_err           : one-cycle FDIV timeout pulse
//
// Build option
//   FPU_TIMEOUT_EN : when defined, FDIV waits are bounded by TIMEOUT cycles.
//                    When undefined, out_err is tied to 0 and FDIV waits
//                    indefinitely for in_fpu_done.

module fpu_seq_ctrl #(
    parameter int LAT_ADD    = 3,
    parameter int LAT_MUL    = 4,
    parameter int LAT_SIMPLE = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic       in_valid,
    input  logic [2:0] in_fp_op,
    input  logic       in_flush,
    input  logic       in_fpu_done,
    input  logic       in_wb_ready,
    output logic       out_fpu_start,
    output logic [2:0] out_fpu_op,
    output logic       out_fpu_kill,
    output logic       out_stall,
    output logic       out_wb_valid,
    output logic [2:0] out_wb_op,
    output logic       out_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    localparam logic [2:0] OP_DIV = 3'b010;

    state_t     state_q;
    logic [2:0] op_q;
    logic [2:0] lat_cnt_q;
    logic       start_q;
    logic       wb_valid_q;
    logic [2:0] lat_load;
    logic       in_div_wait;
    logic       to_expire;

    assign in_div_wait = (state_q == WAIT) && (op_q == OP_DIV);

    // WAIT lasts LAT cycles, so the counter is preloaded with LAT-1 and the
    // move to WB happens in the cycle it reads zero.
    always_comb begin
        lat_load = 3'(LAT_SIMPLE - 1);
        case (op_q)
            3'b000, 3'b100: lat_load = 3'(LAT_ADD - 1);
            3'b001:         lat_load = 3'(LAT_MUL - 1);
            default:        lat_load = 3'(LAT_SIMPLE - 1);
        endcase
    end

`ifdef FPU_TIMEOUT_EN
    logic [6:0] to_cnt_q;

    // to_cnt_q holds the number of FDIV WAIT cycles already completed, so
    // expiry fires in the TIMEOUT-th WAIT cycle. Flush and done both win.
    assign to_expire = in_div_wait && !in_flush && !in_fpu_done &&
                       (to_cnt_q == 7'(TIMEOUT - 1));

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            to_cnt_q <= 7'd0;
        end else if (in_div_wait) begin
            to_cnt_q <= to_cnt_q + 7'd1;
        end else begin
            to_cnt_q <= 7'd0;
        end
    end

    assign out_err = to_expire;
`else
    assign to_expire = 1'b0;
    assign out_err   = 1'b0;
`endif

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q    <= IDLE;
            op_q       <= 3'b000;
            lat_cnt_q  <= 3'd0;
            start_q    <= 1'b0;
            wb_valid_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid && !in_flush) begin
                        op_q    <= in_fp_op;
                        start_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (in_flush) begin
                        state_q <= IDLE;
                    end else begin
                        lat_cnt_q <= lat_load;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (in_flush || to_expire) begin
                        state_q <= IDLE;
                    end else if (op_q == OP_DIV) begin
                        if (in_fpu_done) begin
                            wb_valid_q <= 1'b1;
                            state_q    <= WB;
                        end
                    end else if (lat_cnt_q == 3'd0) begin
                        wb_valid_q <= 1'b1;
                        state_q    <= WB;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 3'd1;
                    end
                end
                WB: begin
                    if (in_flush || in_wb_ready) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Kill and stall must react in the same cycle as flush/request, so they
    // are decoded from the current state rather than registered. The reset
    // gate keeps stall low while reset is asserted.
    assign out_fpu_kill = (in_flush && (state_q == ISSUE || state_q == WAIT)) ||
                          to_expire;
    assign out_stall    = (state_q != IDLE) ||
                          (in_rst_n && in_valid && !in_flush);

    assign out_fpu_start = start_q;
    assign out_fpu_op    = op_q;
    assign out_wb_valid  = wb_valid_q;
    assign out_wb_op     = op_q;

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// tb_fpu_seq_ctrl: directed testbench for fpu_seq_ctrl with a writeback
// scoreboard. Stimulus pushes the expected op class and first-valid cycle of
// each completing operation; a monitor pops and compares on every writeback
// handshake.

module tb_fpu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic [2:0] fp_op;
    logic       flush;
    logic       fpu_done;
    logic       wb_ready;
    logic       fpu_start;
    logic [2:0] fpu_op;
    logic       fpu_kill;
    logic       stall;
    logic       wb_valid;
    logic [2:0] wb_op;
    logic       err;

    typedef struct {
        logic [2:0] op;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   first_cyc = 0;
    logic prev_valid = 1'b0;

    fpu_seq_ctrl dut (
        .in_clk       (clk),
        .in_rst_n     (rst_n),
        .in_valid     (valid),
        .in_fp_op     (fp_op),
        .in_flush     (flush),
        .in_fpu_done  (fpu_done),
        .in_wb_ready  (wb_ready),
        .out_fpu_start(fpu_start),
        .out_fpu_op   (fpu_op),
        .out_fpu_kill (fpu_kill),
        .out_stall    (stall),
        .out_wb_valid (wb_valid),
        .out_wb_op    (wb_op),
        .out_err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic fl,
                                 input logic dn, input logic rdy);
        valid    = v;
        fp_op    = op;
        flush    = fl;
        fpu_done = dn;
        wb_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectWb(input logic [2:0] op, input int at);
        exp_t e;
        e.op  = op;
        e.cyc = at;
        sb.push_back(e);
    endtask

    // Issue one fixed-latency op with wb_ready high and wait (bounded) for
    // its writeback handshake.
    task automatic runOp(input logic [2:0] op, input int lat);
        int  c0;
        bit  done;
        c0   = cyc;
        done = 0;
        expectWb(op, c0 + lat + 2);
        applyStimulus(1'b1, op, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("accept_stall", int'(stall), 1);
        tick();
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("issue_start", int'(fpu_start), 1);
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            @(negedge clk);
            if (wb_valid && wb_ready) done = 1;
        end
        if (!done) checkOutput("runop_wb_timeout", 0, 1);
        tick();
    endtask

    // Scoreboard monitor: compares each writeback handshake against the
    // oldest expectation, including the cycle wb_valid first rose.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (wb_valid && !prev_valid) first_cyc = cyc;
            if (wb_valid && wb_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("wb_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("wb_op", int'(wb_op), int'(e.op));
                    checkOutput("wb_first_cycle", first_cyc, e.cyc);
                end
            end
            prev_valid = wb_valid;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        int err_seen;
        int wb_seen;

        // Reset with a pending request: every output must stay 0.
        rst_n = 1'b0;
        applyStimulus(1'b1, 3'b111, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("rst_stall", int'(stall), 0);
        checkOutput("rst_start", int'(fpu_start), 0);
        checkOutput("rst_wb_valid", int'(wb_valid), 0);
        checkOutput("rst_kill", int'(fpu_kill), 0);
        checkOutput("rst_err", int'(err), 0);
        checkOutput("rst_fpu_op", int'(fpu_op), 0);
        tick();
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        tick();

        // FADD with defaults: stall cycles 0-5, start cycle 1, wb_valid cycle 5.
        c0 = cyc;
        expectWb(3'b000, c0 + 5);
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("fadd_stall_c0", int'(stall), 1);
        checkOutput("fadd_start_c0", int'(fpu_start), 0);
        tick();
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("fadd_start_c1", int'(fpu_start), 1);
        for (int i = 2; i <= 5; i++) begin
            tick();
            @(negedge clk);
            checkOutput("fadd_stall", int'(stall), 1);
            checkOutput("fadd_start_low", int'(fpu_start), 0);
            checkOutput("fadd_wb_valid", int'(wb_valid), (i == 5) ? 1 : 0);
        end
        tick();
        @(negedge clk);
        checkOutput("fadd_idle_stall", int'(stall), 0);
        checkOutput("fadd_idle_wb", int'(wb_valid), 0);

        // FMV: wb_valid in cycle 3, held with wb_op for 4 cycles of wb_ready=0.
        tick();
        c0 = cyc;
        expectWb(3'b111, c0 + 3);
        applyStimulus(1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("fmv_wb_c2", int'(wb_valid), 0);
        for (int i = 3; i <= 6; i++) begin
            tick();
            @(negedge clk);
            checkOutput("fmv_wb_hold", int'(wb_valid), 1);
            checkOutput("fmv_op_hold", int'(wb_op), 7);
        end
        tick();
        wb_ready = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("fmv_released", int'(wb_valid), 0);

        // FDIV: done in IDLE ignored, done in ISSUE ignored, done cycle 20 -> WB cycle 21.
        tick();
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("idle_done_stall", int'(stall), 0);
        tick();
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("idle_done_wb", int'(wb_valid), 0);
        checkOutput("idle_done_start", int'(fpu_start), 0);
        tick();
        c0 = cyc;
        expectWb(3'b010, c0 + 21);
        applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 1'b1);
        tick();
        wb_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b0, 3'b000, 1'b0, (i == 1 || i == 20), 1'b1);
            @(negedge clk);
            if (wb_valid) wb_seen++;
            tick();
        end
        checkOutput("fdiv_early_wb", wb_seen, 0);
        fpu_done = 1'b0;
        @(negedge clk);
        checkOutput("fdiv_wb_c21", int'(wb_valid), 1);
        tick();

        // FMUL flushed in cycle 3: kill in cycle 3, IDLE in cycle 4, no writeback.
        applyStimulus(1'b1, 3'b001, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        @(negedge clk);
        checkOutput("fmul_fpu_op", int'(fpu_op), 1);
        tick();
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_kill_c3", int'(fpu_kill), 1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_kill_c4", int'(fpu_kill), 0);
        checkOutput("flush_idle_stall", int'(stall), 0);
        wb_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wb_valid) wb_seen++;
            tick();
        end
        checkOutput("flush_no_wb", wb_seen, 0);

        // Flush together with a request in IDLE: nothing accepted.
        applyStimulus(1'b1, 3'b000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("flushvalid_stall", int'(stall), 0);
        checkOutput("flushvalid_kill", int'(fpu_kill), 0);
        tick();
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("flushvalid_start", int'(fpu_start), 0);
        checkOutput("flushvalid_stall2", int'(stall), 0);
        tick();

        // Flush in WB drops the result without a kill pulse.
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        valid = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        @(negedge clk);
        checkOutput("wbflush_valid_c5", int'(wb_valid), 1);
        tick();
        flush = 1'b1;
        @(negedge clk);
        checkOutput("wbflush_kill", int'(fpu_kill), 0);
        tick();
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("wbflush_dropped", int'(wb_valid), 0);
        checkOutput("wbflush_stall", int'(stall), 0);
        tick();

        // Reset in mid-WAIT (with flush high): outputs drop at once, no kill.
        applyStimulus(1'b1, 3'b001, 1'b0, 1'b0, 1'b1);
        tick();
        valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        flush = 1'b1;
        #1;
        checkOutput("midrst_stall", int'(stall), 0);
        checkOutput("midrst_kill", int'(fpu_kill), 0);
        checkOutput("midrst_fpu_op", int'(fpu_op), 0);
        checkOutput("midrst_wb", int'(wb_valid), 0);
        checkOutput("midrst_start", int'(fpu_start), 0);
        tick();
        flush = 1'b0;
        rst_n = 1'b1;
        tick();
        runOp(3'b000, 3);

        // Remaining fixed-latency classes.
        runOp(3'b001, 4);
        runOp(3'b100, 3);
        runOp(3'b110, 1);
        runOp(3'b011, 1);
        runOp(3'b101, 1);

        // FDIV with no completion.
        c0 = cyc;
        applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 1'b1);
        tick();
        valid = 1'b0;
`ifdef FPU_TIMEOUT_EN
        err_seen = 0;
        wb_seen  = 0;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (err) begin
                err_seen++;
                checkOutput("timeout_cycle", cyc, c0 + 65);
                checkOutput("timeout_kill", int'(fpu_kill), 1);
            end
            if (wb_valid) wb_seen++;
            tick();
        end
        checkOutput("timeout_err_count", err_seen, 1);
        checkOutput("timeout_no_wb", wb_seen, 0);
        @(negedge clk);
        checkOutput("timeout_idle", int'(stall), 0);
        tick();
`else
        err_seen = 0;
        wb_seen  = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (err) err_seen++;
            if (wb_valid) wb_seen++;
            tick();
        end
        checkOutput("nodiv_err", err_seen, 0);
        checkOutput("nodiv_wb", wb_seen, 0);
        @(negedge clk);
        checkOutput("nodiv_still_wait", int'(stall), 1);
        tick();
        flush = 1'b1;
        @(negedge clk);
        checkOutput("nodiv_flush_kill", int'(fpu_kill), 1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("nodiv_flush_idle", int'(stall), 0);
        tick();
`endif

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_seq_ctrl.md
FPU_SEQ_CTRL -- requirements
Module: fpu_seq_ctrl

Interface
REQ-001 SHALL have parameter LAT_ADD, default 3: cycles in WAIT for op class 000 (FADD/FSUB) and 100 (FCVT); legal range 1-8.
REQ-002 SHALL have parameter LAT_MUL, default 4: cycles in WAIT for op class 001 (FMUL); legal range 1-8.
REQ-003 SHALL have parameter LAT_SIMPLE, default 1: cycles in WAIT for op classes 011, 101, 110, 111 (FMIN/FMAX, FSGNJ*, FEQ/FLT/FLE, FMV); legal range 1-8.
REQ-004 SHALL have parameter TIMEOUT, default 64: maximum WAIT cycles for FDIV; legal range 2-127.
REQ-005 in_clk  input  1  single clock; all state changes on its rising edge.
REQ-006 in_rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  decode presents an FP operation.
REQ-008 in_fp_op  input  3  op class (000 add/sub, 001 mul, 010 div, 011 min/max, 100 cvt, 101 sgnj, 110 cmp, 111 mv).
REQ-009 in_flush  input  1  pipeline flush; discards the in-flight operation.
REQ-010 in_fpu_done  input  1  FDIV completion from the FPU.
REQ-011 in_wb_ready  input  1  writeback accepts the result.
REQ-012 out_fpu_start  output  1  one-cycle start pulse to the FPU.
REQ-013 out_fpu_op  output  3  latched op class driven to the FPU.
REQ-014 out_fpu_kill  output  1  one-cycle abort pulse to the FPU.
REQ-015 out_stall  output  1  front-end stall.
REQ-016 out_wb_valid  output  1  result ready for writeback.
REQ-017 out_wb_op  output  3  op class of the result being written back.
REQ-018 out_err  output  1  one-cycle FDIV timeout pulse.

Function
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, WAIT, WB.
REQ-020 IDLE: in_valid=1 and in_flush=0 SHALL latch in_fp_op and go to ISSUE; otherwise stay.
REQ-021 out_stall SHALL be 1 whenever state is not IDLE, and SHALL also be 1 in IDLE when in_valid=1 and in_flush=0 (combinational).
REQ-022 ISSUE SHALL last exactly one cycle with out_fpu_start=1.
REQ-023 ISSUE SHALL load the 3-bit latency counter with LAT-1 for the latched class, then go to WAIT.
REQ-024 WAIT, non-div classes: a counter value of 0 SHALL go to WB; otherwise the counter decrements. WAIT lasts exactly LAT cycles.
REQ-025 Fixed-latency classes: accept in cycle 0 -> out_fpu_start in cycle 1 -> out_wb_valid first high in cycle LAT+2.
REQ-026 WAIT, class 010: in_fpu_done=1 SHALL go to WB next cycle; in_fpu_done SHALL be ignored in any other state or for any other class.
REQ-027 WB SHALL hold out_wb_valid=1 and out_wb_op stable until in_wb_ready=1, then go to IDLE; new requests are not accepted in WB (one-cycle bubble minimum).
REQ-028 out_fpu_op SHALL equal the latched op in every state.
REQ-029 in_flush=1 in ISSUE or WAIT SHALL pulse out_fpu_kill for one cycle and go to IDLE next cycle; out_wb_valid is not asserted.
REQ-030 in_flush=1 in WB SHALL drop the result and go to IDLE next cycle without a kill pulse.
REQ-031 in_flush=1 takes priority over in_valid, in_fpu_done, counter expiry and in_wb_ready in the same cycle.

Reset
REQ-032 in_rst_n=0 SHALL immediately force state IDLE, latched op 000, all counters 0, and every output 0; no kill pulse is emitted for an operation aborted by reset.

Configuration
REQ-033 With FPU_TIMEOUT_EN defined: a 7-bit counter SHALL count FDIV WAIT cycles; on reaching TIMEOUT without in_fpu_done, the block SHALL pulse out_err and out_fpu_kill together for one cycle and go to IDLE without out_wb_valid. in_fpu_done in the same cycle as expiry SHALL win.
REQ-034 Without FPU_TIMEOUT_EN: out_err SHALL be tied to 0, no timeout counter exists, and FDIV waits indefinitely for in_fpu_done.

Verification
REQ-035 FADD, defaults: in_valid with op 000 in cycle 0 -> start in cycle 1 -> wb_valid in cycle 5; stall high cycles 0-5 with wb_ready=1 in cycle 5.
REQ-036 FMV, LAT_SIMPLE=1: accept in cycle 0 -> wb_valid in cycle 3, wb_op=111; wb_ready held 0 for 4 cycles -> wb_valid and wb_op held.
REQ-037 FDIV, done in cycle 20 -> wb_valid in cycle 21; an in_fpu_done pulse in IDLE has no effect.
REQ-038 Flush in cycle 3 of FMUL -> kill pulse in cycle 3, IDLE in cycle 4, no wb_valid; flush plus in_valid in IDLE -> no accept.
REQ-039 With FPU_TIMEOUT_EN and TIMEOUT=64, FDIV with no done -> err and kill pulse after 64 WAIT cycles, then IDLE; without the macro -> stays in WAIT and err=0.
REQ-040 in_rst_n low in mid-WAIT -> all outputs 0 at once, no kill pulse; the first request after release follows REQ-035 timing.
